// File: rtl/regfile_sb.sv
// regfile_sb
//    Parametrised register file for the RISC datapath. It has one write port,
//    two independent combinational read ports, optional same-cycle write-to-read
//    bypass and an optional hardwired-zero register 0. A per-register pending
//    (scoreboard) bit lets the controller reserve a destination register. Reads
//    that depend on an outstanding write then report busy.
//
// Parameters
//    WIDTH     data width
//    DEPTH     number of registers (power of two, >= 2)
//    AW        register-number width, derived from DEPTH
//    BYPASS    1: a same-cycle write is forwarded to the read ports
//    ZERO_REG  1: register 0 reads 0 and is never written or reserved
//
// Ports
//    clk, rst_n               rising-edge clock, async active-low reset
//    data_in/writenum/write   write port
//    readnum_a/data_out_a     read port A
//    readnum_b/data_out_b     read port B
//    reserve/reservenum       set pending bit of reservenum
//    busy_a/busy_b            selected register has an outstanding producer
//    pending                  all pending bits, bit i = register i

module regfile_sb #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = $clog2(DEPTH),
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    writenum,
   input  logic             write,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   output logic [WIDTH-1:0] data_out_a,
   output logic [WIDTH-1:0] data_out_b,
   input  logic             reserve,
   input  logic [AW-1:0]    reservenum,
   output logic             busy_a,
   output logic             busy_b,
   output logic [DEPTH-1:0] pending
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_pending;

   logic             w_wr_en;
   logic             w_hit_a;
   logic             w_hit_b;
   logic [DEPTH-1:0] w_pend_nxt;

   // Writes that target a hardwired-zero register 0 are dropped.
   assign w_wr_en = write && !((ZERO_REG != 0) && (writenum == '0));

   // Read-port hits on the in-flight write. These are used for bypass and
   // for busy suppression.
   assign w_hit_a = (BYPASS != 0) && write && (writenum == readnum_a);
   assign w_hit_b = (BYPASS != 0) && write && (writenum == readnum_b);

   // Storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i[AW-1:0]] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[writenum] <= data_in;
      end
   end

   // Pending-bit update. The reserve is applied after the write-clear, so
   // set wins when both name the same register. Register 0 is forced clear
   // when it is hardwired to zero.
   always_comb begin
      w_pend_nxt = r_pending;
      if (write) begin
         w_pend_nxt[writenum] = 1'b0;
      end
      if (reserve) begin
         w_pend_nxt[reservenum] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_pend_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pend_nxt;
      end
   end

   // Read ports. Zero-register forcing takes priority over bypass.
   always_comb begin
      data_out_a = r_mem[readnum_a];
      if ((ZERO_REG != 0) && (readnum_a == '0)) begin
         data_out_a = '0;
      end else if (w_hit_a) begin
         data_out_a = data_in;
      end
   end

   always_comb begin
      data_out_b = r_mem[readnum_b];
      if ((ZERO_REG != 0) && (readnum_b == '0)) begin
         data_out_b = '0;
      end else if (w_hit_b) begin
         data_out_b = data_in;
      end
   end

   // A read that bypass already satisfies does not stall.
   assign busy_a  = r_pending[readnum_a] && !w_hit_a;
   assign busy_b  = r_pending[readnum_b] && !w_hit_b;
   assign pending = r_pending;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//    Bench for regfile_sb. Three instances share the stimulus: bypass on,
//    bypass off, and bypass on with hardwired-zero register 0. A behavioural
//    model per instance produces expected values. These are queued when a
//    cycle is driven and compared when the outputs are sampled mid-cycle.

module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic [2:0]  writenum, readnum_a, readnum_b, reservenum;
   logic        write, reserve;

   logic [15:0] da0, db0, da1, db1, da2, db2;
   logic        ba0, bb0, ba1, bb1, ba2, bb2;
   logic [7:0]  pd0, pd1, pd2;

   always #5 clk = ~clk;

   regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_byp (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da0), .data_out_b(db0),
      .reserve(reserve), .reservenum(reservenum), .busy_a(ba0), .busy_b(bb0), .pending(pd0));

   regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da1), .data_out_b(db1),
      .reserve(reserve), .reservenum(reservenum), .busy_a(ba1), .busy_b(bb1), .pending(pd1));

   regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) u_zero (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(da2), .data_out_b(db2),
      .reserve(reserve), .reservenum(reservenum), .busy_a(ba2), .busy_b(bb2), .pending(pd2));

   typedef struct {
      int          k;
      int          s;
      logic [15:0] e;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          byp_p[3] = '{1, 0, 1};
   int          zr_p[3]  = '{0, 0, 1};
   string       inst_n[3] = '{"byp", "nob", "zero"};
   string       sig_n[5]  = '{"dout_a", "dout_b", "busy_a", "busy_b", "pending"};
   logic [15:0] m_mem[3][8];
   logic [7:0]  m_pend[3];
   string       phase;

   task automatic chk(input string tag, input logic [15:0] obs_v, input logic [15:0] exp_v);
      n_tests++;
      if (obs_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs_v, exp_v, $time);
      end
   endtask

   function automatic logic [15:0] obs(input int k, input int s);
      logic [15:0] v;
      v = 'x;
      case (k)
         0: case (s) 0: v = da0; 1: v = db0; 2: v = {15'd0, ba0}; 3: v = {15'd0, bb0}; default: v = {8'd0, pd0}; endcase
         1: case (s) 0: v = da1; 1: v = db1; 2: v = {15'd0, ba1}; 3: v = {15'd0, bb1}; default: v = {8'd0, pd1}; endcase
         default: case (s) 0: v = da2; 1: v = db2; 2: v = {15'd0, ba2}; 3: v = {15'd0, bb2}; default: v = {8'd0, pd2}; endcase
      endcase
      return v;
   endfunction

   function automatic logic [15:0] exp_rd(input int k, input logic [2:0] rn);
      if (zr_p[k] != 0 && rn == 3'd0) return 16'h0000;
      if (byp_p[k] != 0 && write && writenum == rn) return data_in;
      return m_mem[k][rn];
   endfunction

   function automatic logic exp_busy(input int k, input logic [2:0] rn);
      return m_pend[k][rn] && !(byp_p[k] != 0 && write && writenum == rn);
   endfunction

   task automatic push_all();
      exp_t x;
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 5; s++) begin
            x.k = k;
            x.s = s;
            x.tag = $sformatf("%s/%s/%s", phase, inst_n[k], sig_n[s]);
            case (s)
               0: x.e = exp_rd(k, readnum_a);
               1: x.e = exp_rd(k, readnum_b);
               2: x.e = {15'd0, exp_busy(k, readnum_a)};
               3: x.e = {15'd0, exp_busy(k, readnum_b)};
               default: x.e = {8'd0, m_pend[k]};
            endcase
            sbq.push_back(x);
         end
      end
   endtask

   task automatic drain();
      exp_t x;
      while (sbq.size() > 0) begin
         x = sbq.pop_front();
         chk(x.tag, obs(x.k, x.s), x.e);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         m_pend[k] = 8'h00;
         for (int r = 0; r < 8; r++) m_mem[k][r] = 16'h0000;
      end
   endtask

   task automatic m_edge();
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (write && !(zr_p[k] != 0 && writenum == 3'd0)) m_mem[k][writenum] = data_in;
            if (write) m_pend[k][writenum] = 1'b0;
            if (reserve && !(zr_p[k] != 0 && reservenum == 3'd0)) m_pend[k][reservenum] = 1'b1;
         end
      end
   endtask

   // One clock cycle: drive, queue expectations, compare mid-cycle, advance.
   task automatic cyc(input string ph, input logic w, input logic [2:0] wn, input logic [15:0] d,
                      input logic [2:0] ra, input logic [2:0] rb,
                      input logic rs, input logic [2:0] rsn);
      phase      = ph;
      write      = w;
      writenum   = wn;
      data_in    = d;
      readnum_a  = ra;
      readnum_b  = rb;
      reserve    = rs;
      reservenum = rsn;
      push_all();
      @(negedge clk);
      drain();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      write = 1'b0; writenum = '0; data_in = '0; readnum_a = '0; readnum_b = '0;
      reserve = 1'b0; reservenum = '0;
      m_reset();
      #2;
      phase = "rst0";
      push_all();
      drain();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset: write reg 3 and reserve it, then pulse reset mid-cycle.
      cyc("w3",     1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd7, 1'b1, 3'd3);
      write = 1'b0; reserve = 1'b0; readnum_a = 3'd3;
      #1;
      phase = "pre_rst";
      push_all();
      drain();
      rst_n = 1'b0;
      #1;
      m_reset();
      phase = "mid_rst";
      push_all();
      drain();
      // Writes and reserves are ignored while held in reset; bypass stays live.
      cyc("in_rst", 1'b1, 3'd5, 16'h7777, 3'd5, 3'd3, 1'b1, 3'd5);
      rst_n = 1'b1;
      cyc("post_rst", 1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 1'b0, 3'd0);

      // Two read ports
      cyc("w5",     1'b1, 3'd5, 16'h1234, 3'd1, 3'd2, 1'b0, 3'd0);
      cyc("w2",     1'b1, 3'd2, 16'hABCD, 3'd5, 3'd7, 1'b0, 3'd0);
      cyc("rd52",   1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 1'b0, 3'd0);
      cyc("rd77",   1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, 1'b0, 3'd0);
      cyc("rd55",   1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 3'd0);

      // Bypass on the write cycle, stored value afterwards
      cyc("byp4",   1'b1, 3'd4, 16'h00FF, 3'd4, 3'd4, 1'b0, 3'd0);
      cyc("rd4",    1'b0, 3'd0, 16'h0000, 3'd4, 3'd5, 1'b0, 3'd0);
      cyc("byp4b",  1'b1, 3'd4, 16'h0F0F, 3'd4, 3'd2, 1'b0, 3'd0);

      // Scoreboard: reserve 6, observe busy, then write 6
      cyc("rsv6",   1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b1, 3'd6);
      cyc("busy6",  1'b0, 3'd0, 16'h0000, 3'd6, 3'd5, 1'b0, 3'd0);
      cyc("wr6",    1'b1, 3'd6, 16'h6666, 3'd6, 3'd6, 1'b0, 3'd0);
      cyc("clr6",   1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b0, 3'd0);

      // Simultaneous reserve and write of an already-pending register
      cyc("rsv1",   1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 1'b1, 3'd1);
      cyc("rsv1a",  1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 1'b1, 3'd1);
      cyc("rw1",    1'b1, 3'd1, 16'h5555, 3'd1, 3'd2, 1'b1, 3'd1);
      cyc("chk1",   1'b0, 3'd0, 16'h0000, 3'd1, 3'd1, 1'b0, 3'd0);
      cyc("wr1",    1'b1, 3'd1, 16'hAAAA, 3'd2, 3'd1, 1'b0, 3'd0);
      cyc("wr1np",  1'b1, 3'd1, 16'h1111, 3'd1, 3'd1, 1'b0, 3'd0);

      // Register 0: hardwired zero on one instance only
      cyc("w0",     1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0);
      cyc("rd0",    1'b0, 3'd0, 16'h0000, 3'd0, 3'd4, 1'b0, 3'd0);
      cyc("w0b",    1'b1, 3'd0, 16'h1357, 3'd0, 3'd1, 1'b0, 3'd0);
      cyc("rd0b",   1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0);

      // Short random phase against the same model
      for (int n = 0; n < 40; n++) begin
         cyc("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
